// File: rtl/mem_req_arbiter_2port.sv
// Shares one single-port memory between two requesters: round-robin request grant,
// plus an in-order FIFO of port IDs that steers each memory response to its issuer.
module mem_req_arbiter_2port #(
    parameter int p_addr_sz      = 16,
    parameter int p_data_sz      = 32,
    parameter int p_max_inflight = 4,
    localparam int c_len_sz      = $clog2(p_data_sz / 8),
    localparam int c_req_sz      = 1 + p_addr_sz + c_len_sz + p_data_sz,
    localparam int c_resp_sz     = 1 + c_len_sz + p_data_sz
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req0_val,
    output logic                 req0_rdy,
    input  logic [c_req_sz-1:0]  req0_msg,
    output logic                 resp0_val,
    input  logic                 resp0_rdy,
    output logic [c_resp_sz-1:0] resp0_msg,

    input  logic                 req1_val,
    output logic                 req1_rdy,
    input  logic [c_req_sz-1:0]  req1_msg,
    output logic                 resp1_val,
    input  logic                 resp1_rdy,
    output logic [c_resp_sz-1:0] resp1_msg,

    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    output logic [c_req_sz-1:0]  memreq_msg,
    input  logic                 memresp_val,
    output logic                 memresp_rdy,
    input  logic [c_resp_sz-1:0] memresp_msg
);

    // state  | meaning
    // prio=0 | port 0 wins when both requesters are valid
    // prio=1 | port 1 wins when both requesters are valid

    localparam int c_ptr_sz = $clog2(p_max_inflight);
    localparam int c_cnt_sz = c_ptr_sz + 1;
    localparam logic [c_cnt_sz-1:0] c_full_cnt = c_cnt_sz'(p_max_inflight);

    logic                      prio,   prio_nxt;
    logic [c_cnt_sz-1:0]       count,  count_nxt;
    logic [c_ptr_sz-1:0]       wr_ptr, wr_ptr_nxt;
    logic [c_ptr_sz-1:0]       rd_ptr, rd_ptr_nxt;
    logic [p_max_inflight-1:0] tag_q;

    logic full;
    logic empty;
    logic grant_id;
    logic head_id;
    logic req_fire;
    logic resp_fire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio   <= 1'b0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            prio   <= prio_nxt;
            count  <= count_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Tag storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[wr_ptr] <= grant_id;
        end
    end

    always_comb begin
        prio_nxt   = prio;
        count_nxt  = count;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (req_fire) begin
            prio_nxt   = ~grant_id;
            wr_ptr_nxt = wr_ptr + 1'b1;
        end
        if (resp_fire) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
        case ({req_fire, resp_fire})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        full    = (count == c_full_cnt);
        empty   = (count == '0);
        head_id = tag_q[rd_ptr];

        if (req0_val && req1_val) begin
            grant_id = prio;
        end else begin
            grant_id = req1_val;
        end

        // A pop in the same cycle never frees a slot for a new grant.
        memreq_val = reset && (req0_val || req1_val) && !full;
        memreq_msg = grant_id ? req1_msg : req0_msg;
        req0_rdy   = reset && req0_val && !grant_id && memreq_rdy && !full;
        req1_rdy   = reset && req1_val &&  grant_id && memreq_rdy && !full;

        resp0_val   = reset && !empty && !head_id && memresp_val;
        resp1_val   = reset && !empty &&  head_id && memresp_val;
        memresp_rdy = reset && !empty && (head_id ? resp1_rdy : resp0_rdy);
        resp0_msg   = memresp_msg;
        resp1_msg   = memresp_msg;

        req_fire  = memreq_val && memreq_rdy;
        resp_fire = memresp_val && memresp_rdy;
    end

endmodule
